// File: rtl/wave_voice_scheduler.sv
// Scans NUM_CH tone voices through one shared wave_lut each sample frame, mixes them, and arbitrates host wave-memory writes.
// Optional feature: define WAVE_SCHED_PHASE_SYNC_EN to add phase_sync_in, which zeroes all phases at the next frame start.
module wave_voice_scheduler #(
    parameter  int unsigned NUM_CH     = 4,
    parameter  int unsigned PHASE_W    = 16,
    parameter  int unsigned SAMPLE_DIV = 64,
    localparam int unsigned SEL_W      = $clog2(NUM_CH),
    localparam int unsigned SMP_W      = 8 + SEL_W
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
`ifdef WAVE_SCHED_PHASE_SYNC_EN
    input  logic               phase_sync_in,
`endif
    input  logic               ch_cfg_we_in,
    input  logic [SEL_W-1:0]   ch_cfg_sel_in,
    input  logic [PHASE_W-1:0] ch_freq_in,
    input  logic [2:0]         ch_wave_type_in,
    input  logic [3:0]         ch_vol_in,
    input  logic               ch_en_in,
    input  logic               wr_req_in,
    input  logic [3:0]         wr_addr_in,
    input  logic [3:0]         wr_data_in,
    output logic               wr_ack_out,
    output logic [3:0]         lut_addr_out,
    output logic [2:0]         lut_wave_type_out,
    input  logic [15:0]        lut_data_in,
    output logic [3:0]         mem_write_addr_out,
    output logic [3:0]         mem_write_data_out,
    output logic               mem_write_en_out,
    output logic [SMP_W-1:0]   sample_out,
    output logic               sample_valid_out
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

    typedef struct packed {
        logic [PHASE_W-1:0] freq;
        logic [2:0]         wave_type;
        logic [3:0]         vol;
        logic               en;
    } voice_cfg_t;

    voice_cfg_t         cfg   [NUM_CH];
    logic [PHASE_W-1:0] phase [NUM_CH];

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_next_c;
    logic             frame_end_c;
    logic             scan_c;
    logic             scan_next_c;
    logic             last_scan_c;
    logic [SEL_W-1:0] ch_idx_c;
    logic [3:0]       amp_c;
    logic [7:0]       contrib_c;
    logic [SMP_W-1:0] acc;
    logic             grant_c;
    logic             sync_now_c;
    logic             unused_lut_bits;

    // Frame position decode; the scan window is the first NUM_CH cycles of each frame.
    always_comb begin : frame_decode
        frame_end_c = (div_cnt == CNT_W'(SAMPLE_DIV - 1));
        div_next_c  = frame_end_c ? '0 : div_cnt + CNT_W'(1);
        scan_c      = (div_cnt < CNT_W'(NUM_CH));
        scan_next_c = (div_next_c < CNT_W'(NUM_CH));
        last_scan_c = (div_cnt == CNT_W'(NUM_CH - 1));
        ch_idx_c    = SEL_W'(div_cnt);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin : frame_counter
        if (!rst_n_in) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_next_c;
        end
    end

    // Present the scanned voice to the LUT and scale its returned amplitude.
    always_comb begin : voice_mux
        lut_addr_out      = '0;
        lut_wave_type_out = '0;
        amp_c             = '0;
        contrib_c         = '0;
        if (scan_c) begin
            lut_addr_out      = phase[ch_idx_c][PHASE_W-1 -: 4];
            lut_wave_type_out = cfg[ch_idx_c].wave_type;
            amp_c             = cfg[ch_idx_c].wave_type[2] ? lut_data_in[15:12]
                                                           : {4{lut_data_in[0]}};
            if (cfg[ch_idx_c].en) begin
                contrib_c = 8'(amp_c) * 8'(cfg[ch_idx_c].vol);
            end
        end
    end

    assign unused_lut_bits = ^lut_data_in[11:1];

`ifdef WAVE_SCHED_PHASE_SYNC_EN
    logic sync_pend;

    // A sync pulse is remembered until the frame wraps, so a scan never sees a partial reset.
    assign sync_now_c = frame_end_c && (sync_pend || phase_sync_in);

    always_ff @(posedge clk_in or negedge rst_n_in) begin : sync_flag
        if (!rst_n_in) begin
            sync_pend <= 1'b0;
        end else if (sync_now_c) begin
            sync_pend <= 1'b0;
        end else if (phase_sync_in) begin
            sync_pend <= 1'b1;
        end
    end
`else
    assign sync_now_c = 1'b0;
`endif

    // Phase advances only at the end of its own scan slot; a config write wins the same edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin : voice_regs
        if (!rst_n_in) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                cfg[i]   <= '0;
                phase[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (scan_c && (ch_idx_c == SEL_W'(i))) begin
                    phase[i] <= cfg[i].en ? phase[i] + cfg[i].freq : '0;
                end
                if (sync_now_c) begin
                    phase[i] <= '0;
                end
                if (ch_cfg_we_in && (ch_cfg_sel_in == SEL_W'(i))) begin
                    cfg[i] <= '{freq: ch_freq_in, wave_type: ch_wave_type_in,
                                vol: ch_vol_in, en: ch_en_in};
                    if (!ch_en_in) begin
                        phase[i] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin : mixer
        if (!rst_n_in) begin
            acc              <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            sample_valid_out <= last_scan_c;
            if (div_cnt == '0) begin
                acc <= SMP_W'(contrib_c);
            end else if (scan_c) begin
                acc <= acc + SMP_W'(contrib_c);
            end
            if (last_scan_c) begin
                sample_out <= acc + SMP_W'(contrib_c);
            end
        end
    end

    // Grant only when the following cycle is outside the scan, so the LUT is stable while scanning.
    assign grant_c = wr_req_in && !wr_ack_out && !scan_next_c;

    always_ff @(posedge clk_in or negedge rst_n_in) begin : write_arb
        if (!rst_n_in) begin
            wr_ack_out         <= 1'b0;
            mem_write_addr_out <= '0;
            mem_write_data_out <= '0;
        end else begin
            wr_ack_out <= grant_c;
            if (grant_c) begin
                mem_write_addr_out <= wr_addr_in;
                mem_write_data_out <= wr_data_in;
            end
        end
    end

    assign mem_write_en_out = wr_ack_out;

endmodule

// File: tb/tb_wave_voice_scheduler.sv
// Directed bench for wave_voice_scheduler: a frame-level reference model checked every cycle,
// a stand-in wave_lut, and hand-computed checkpoints.
module tb_wave_voice_scheduler;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned PHASE_W    = 16;
    localparam int unsigned SAMPLE_DIV = 64;
    localparam int unsigned SMP_W      = 10;

    logic               clk_in          = 1'b0;
    logic               rst_n_in        = 1'b0;
    logic               ch_cfg_we_in    = 1'b0;
    logic [1:0]         ch_cfg_sel_in   = '0;
    logic [PHASE_W-1:0] ch_freq_in      = '0;
    logic [2:0]         ch_wave_type_in = '0;
    logic [3:0]         ch_vol_in       = '0;
    logic               ch_en_in        = 1'b0;
    logic               wr_req_in       = 1'b0;
    logic [3:0]         wr_addr_in      = '0;
    logic [3:0]         wr_data_in      = '0;
    logic               wr_ack_out;
    logic [3:0]         lut_addr_out;
    logic [2:0]         lut_wave_type_out;
    logic [15:0]        lut_data_in;
    logic [3:0]         mem_write_addr_out;
    logic [3:0]         mem_write_data_out;
    logic               mem_write_en_out;
    logic [SMP_W-1:0]   sample_out;
    logic               sample_valid_out;
`ifdef WAVE_SCHED_PHASE_SYNC_EN
    logic               phase_sync_in   = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    wave_voice_scheduler #(
        .NUM_CH    (NUM_CH),
        .PHASE_W   (PHASE_W),
        .SAMPLE_DIV(SAMPLE_DIV)
    ) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
`ifdef WAVE_SCHED_PHASE_SYNC_EN
        .phase_sync_in     (phase_sync_in),
`endif
        .ch_cfg_we_in      (ch_cfg_we_in),
        .ch_cfg_sel_in     (ch_cfg_sel_in),
        .ch_freq_in        (ch_freq_in),
        .ch_wave_type_in   (ch_wave_type_in),
        .ch_vol_in         (ch_vol_in),
        .ch_en_in          (ch_en_in),
        .wr_req_in         (wr_req_in),
        .wr_addr_in        (wr_addr_in),
        .wr_data_in        (wr_data_in),
        .wr_ack_out        (wr_ack_out),
        .lut_addr_out      (lut_addr_out),
        .lut_wave_type_out (lut_wave_type_out),
        .lut_data_in       (lut_data_in),
        .mem_write_addr_out(mem_write_addr_out),
        .mem_write_data_out(mem_write_data_out),
        .mem_write_en_out  (mem_write_en_out),
        .sample_out        (sample_out),
        .sample_valid_out  (sample_valid_out)
    );

    always #5 clk_in = ~clk_in;

    // Stand-in wave_lut: wave memory nibble on top for bit2 types, square (top address bit) in bit 0
    // otherwise; the unused fields carry filler so a wrong field selection shows up in the mix.
    logic [3:0] lut_mem [16] = '{default: 4'h0};

    always @(posedge clk_in) begin
        if (mem_write_en_out) lut_mem[mem_write_addr_out] <= mem_write_data_out;
    end

    always_comb begin
        if (lut_wave_type_out[2]) lut_data_in = {lut_mem[lut_addr_out], 11'h2AA, 1'b0};
        else                      lut_data_in = {4'h9, 11'h2AA, lut_addr_out[3]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: frame position, per-voice settings, wave memory and pending grant.
    int m_div;
    int m_phase   [NUM_CH];
    int m_freq    [NUM_CH];
    int m_type    [NUM_CH];
    int m_vol     [NUM_CH];
    bit m_en      [NUM_CH];
    int m_contrib [NUM_CH];
    int m_mem     [16] = '{default: 0};
    int m_sample;
    bit m_ack;
    int m_waddr;
    int m_wdata;
    int e_addr, e_type, v, amp, sum, nxt, sel;

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            m_div = 0; m_sample = 0; m_ack = 1'b0; m_waddr = 0; m_wdata = 0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                m_phase[k] = 0; m_freq[k] = 0; m_type[k] = 0;
                m_vol[k] = 0; m_en[k] = 1'b0; m_contrib[k] = 0;
            end
            check("rst_lut_addr", 32'(lut_addr_out), 32'(0));
            check("rst_lut_type", 32'(lut_wave_type_out), 32'(0));
            check("rst_sample", 32'(sample_out), 32'(0));
            check("rst_valid", 32'(sample_valid_out), 32'(0));
            check("rst_ack", 32'(wr_ack_out), 32'(0));
            check("rst_mem_we", 32'(mem_write_en_out), 32'(0));
            check("rst_mem_addr", 32'(mem_write_addr_out), 32'(0));
            check("rst_mem_data", 32'(mem_write_data_out), 32'(0));
        end else begin
            v = m_div;
            if (m_div < int'(NUM_CH)) begin
                e_addr = m_phase[v] / 4096;
                e_type = m_type[v];
            end else begin
                e_addr = 0;
                e_type = 0;
            end
            check("lut_addr", 32'(lut_addr_out), 32'(e_addr));
            check("lut_type", 32'(lut_wave_type_out), 32'(e_type));
            check("valid", 32'(sample_valid_out), 32'(m_div == int'(NUM_CH)));
            check("sample", 32'(sample_out), 32'(m_sample));
            check("ack", 32'(wr_ack_out), 32'(m_ack));
            check("mem_we", 32'(mem_write_en_out), 32'(m_ack));
            if (m_ack) begin
                check("mem_addr", 32'(mem_write_addr_out), 32'(m_waddr));
                check("mem_data", 32'(mem_write_data_out), 32'(m_wdata));
            end
            if (m_div < int'(NUM_CH)) begin
                amp = (m_type[v] >= 4) ? m_mem[m_phase[v] / 4096]
                                       : ((m_phase[v] >= 32768) ? 15 : 0);
                m_contrib[v] = m_en[v] ? amp * m_vol[v] : 0;
                m_phase[v]   = m_en[v] ? (m_phase[v] + m_freq[v]) % 65536 : 0;
                if (m_div == int'(NUM_CH) - 1) begin
                    sum = 0;
                    for (int k = 0; k < int'(NUM_CH); k++) sum += m_contrib[k];
                    m_sample = sum;
                end
            end
            sel = int'(ch_cfg_sel_in);
            if (ch_cfg_we_in && sel < int'(NUM_CH)) begin
                m_freq[sel] = int'(ch_freq_in);
                m_type[sel] = int'(ch_wave_type_in);
                m_vol[sel]  = int'(ch_vol_in);
                m_en[sel]   = ch_en_in;
                if (!ch_en_in) m_phase[sel] = 0;
            end
            if (m_ack) m_mem[m_waddr] = m_wdata;
            nxt = (m_div + 1) % int'(SAMPLE_DIV);
            if (wr_req_in && !m_ack && nxt >= int'(NUM_CH)) begin
                m_ack   = 1'b1;
                m_waddr = int'(wr_addr_in);
                m_wdata = int'(wr_data_in);
            end else begin
                m_ack = 1'b0;
            end
            m_div = nxt;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_div(input int d);
        int n = 0;
        do begin
            step();
            n++;
        end while (m_div != d && n < 2 * int'(SAMPLE_DIV));
        if (m_div != d) check("wait_div_timeout", 32'(m_div), 32'(d));
    endtask

    task automatic cfg_write(input int s, input int f, input int t, input int vol, input bit en);
        ch_cfg_sel_in   = 2'(s);
        ch_freq_in      = 16'(f);
        ch_wave_type_in = 3'(t);
        ch_vol_in       = 4'(vol);
        ch_en_in        = en;
        ch_cfg_we_in    = 1'b1;
        step();
        ch_cfg_we_in    = 1'b0;
    endtask

    task automatic write_mem(input int a, input int d);
        int n = 0;
        wr_addr_in = 4'(a);
        wr_data_in = 4'(d);
        wr_req_in  = 1'b1;
        do begin
            step();
            n++;
        end while (!wr_ack_out && n < 200);
        if (!wr_ack_out) check("write_ack_timeout", 32'(wr_ack_out), 32'(1));
        wr_req_in = 1'b0;
        step();
    endtask

    int n;

    initial begin
        repeat (3) step();
        check("reset_sample_lit", 32'(sample_out), 32'(0));
        check("reset_valid_lit", 32'(sample_valid_out), 32'(0));
        rst_n_in = 1'b1;

        // First pulse 4 cycles after release, then once per 64-cycle frame.
        n = 0;
        do begin step(); n++; end while (!sample_valid_out && n < 100);
        check("first_valid_cycle", 32'(n), 32'(4));
        n = 0;
        do begin step(); n++; end while (!sample_valid_out && n < 200);
        check("valid_period", 32'(n), 32'(64));
        check("idle_sample", 32'(sample_out), 32'(0));

        // Square voice stepping one LUT address per frame.
        wait_div(10);
        cfg_write(0, 16'h1000, 0, 15, 1'b1);
        for (int k = 0; k < 16; k++) begin
            wait_div(0);
            check("ch0_addr_step", 32'(lut_addr_out), 32'(k));
            wait_div(4);
            check("ch0_square_sample", 32'(sample_out), (k >= 8) ? 32'(225) : 32'(0));
        end

        // Write granted right after a request outside the scan window.
        wait_div(10);
        wr_addr_in = 4'h5; wr_data_in = 4'hA; wr_req_in = 1'b1;
        step();
        check("wr11_ack", 32'(wr_ack_out), 32'(1));
        check("wr11_we", 32'(mem_write_en_out), 32'(1));
        check("wr11_addr", 32'(mem_write_addr_out), 32'(5));
        check("wr11_data", 32'(mem_write_data_out), 32'(10));
        wr_req_in = 1'b0;

        // Request during the scan waits until the first cycle after it.
        wait_div(2);
        wr_addr_in = 4'h3; wr_data_in = 4'h6; wr_req_in = 1'b1;
        step();
        check("wr_scan_no_ack", 32'(wr_ack_out), 32'(0));
        step();
        check("wr_scan_ack_div4", 32'(wr_ack_out), 32'(1));
        check("wr_scan_addr", 32'(mem_write_addr_out), 32'(3));
        check("wr_scan_data", 32'(mem_write_data_out), 32'(6));
        wr_req_in = 1'b0;
        step();

        // Fill wave memory with full scale, then run four wave-memory voices.
        for (int a = 0; a < 16; a++) write_mem(a, 15);
        wait_div(10);
        cfg_write(0, 16'h1000, 4, 15, 1'b1);
        cfg_write(1, 16'hFFFF, 4, 15, 1'b1);
        cfg_write(2, 16'h0123, 4, 15, 1'b1);
        cfg_write(3, 16'h0000, 4, 15, 1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_div(1);
            check("ch1_addr_seq", 32'(lut_addr_out), (k == 0) ? 32'(0) : 32'(15));
            check("ch1_type", 32'(lut_wave_type_out), 32'(4));
            wait_div(4);
            check("four_voice_sample", 32'(sample_out), 32'(900));
        end

        // Disabling a voice zeroes its phase and removes it from the next mix.
        wait_div(20);
        cfg_write(1, 16'hFFFF, 4, 15, 1'b0);
        wait_div(1);
        check("ch1_disabled_addr", 32'(lut_addr_out), 32'(0));
        wait_div(4);
        check("three_voice_sample", 32'(sample_out), 32'(675));

        // Reset mid-frame with a grant in flight; the host keeps requesting through it.
        wait_div(19);
        wr_addr_in = 4'h7; wr_data_in = 4'h2; wr_req_in = 1'b1;
        step();
        rst_n_in = 1'b0;
        #1;
        check("midrst_ack", 32'(wr_ack_out), 32'(0));
        check("midrst_we", 32'(mem_write_en_out), 32'(0));
        check("midrst_sample", 32'(sample_out), 32'(0));
        check("midrst_lut_addr", 32'(lut_addr_out), 32'(0));
        repeat (3) step();
        rst_n_in = 1'b1;
        n = 0;
        do begin step(); n++; end while (!sample_valid_out && n < 100);
        check("rerun_first_valid", 32'(n), 32'(4));
        check("rerun_ack", 32'(wr_ack_out), 32'(1));
        check("rerun_addr", 32'(mem_write_addr_out), 32'(7));
        check("rerun_data", 32'(mem_write_data_out), 32'(2));
        wr_req_in = 1'b0;
        repeat (70) step();
        check("lut_mem7_written", 32'(lut_mem[7]), 32'(2));

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        if (!done) begin
            n_fail++;
            $display("FAIL watchdog: got no completion, expected completion before time limit");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

endmodule
